pe_requant_drain: RTL and testbench
===================================

// Module: pe_requant_drain
// PURPOSE
//  Downstream of the dual-lane signed MAC PE. Captures the PE's two final
//  accumulator results (lane A, lane B) on a valid pulse, then requantizes
//  each back to int8 with a rounding arithmetic right shift and saturation.
//  Pushes each {B,A} int8 pair into a small FIFO drained over valid/ready.
// PARAMETERS
//  ACC_WIDTH    22  signed accumulator width per lane (PE INPUT_WIDTH+14)
//  OUT_WIDTH    8   signed output width per lane
//  SHIFT_WIDTH  5   width of the requant shift amount
//  FIFO_DEPTH   4   output FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1              clock, rising edge
//  reset       in   1              reset, asynchronous, active-high
//  acc_valid   in   1              1-cycle pulse: acc_a/acc_b/shift valid
//  acc_a       in   ACC_WIDTH      lane A accumulator, two's complement
//  acc_b       in   ACC_WIDTH      lane B accumulator, two's complement
//  shift       in   SHIFT_WIDTH    right-shift amount, sampled with acc_valid
//  out_valid   out  1              FIFO non-empty
//  out_ready   in   1              consumer accepts head entry
//  out_data    out  2*OUT_WIDTH    {lane B int8, lane A int8} at FIFO head
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
//  overflow    out  1              sticky: a result was dropped (FIFO full)
//  clear_ovf   in   1              synchronous clear of overflow
// BEHAVIOUR
//  Reset: all pipeline valids, FIFO pointers and overflow cleared at once;
//   out_valid=0, fifo_count=0, overflow=0, out_data=0.
//  S1 (cycle N, acc_valid=1): register acc_a, acc_b, shift; v1<=1.
//   shift > ACC_WIDTH-1 is clamped to ACC_WIDTH-1.
//  S2 (N+1): per lane, in ACC_WIDTH+1 bits, sign-extended:
//   s=0: r=acc; s>0: r=(acc + 2^(s-1)) >>> s (round half toward +inf).
//  S3 (N+2): saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and push
//   {satB,satA}; entry visible (out_valid=1) in cycle N+3. Latency 3.
//  Back-to-back acc_valid every cycle supported; no input backpressure.
//  FIFO: pop when out_valid&&out_ready; out_data = head entry (from storage,
//   stable while out_valid&&!out_ready). Pointers wrap modulo FIFO_DEPTH.
//  Push when full and no pop: entry dropped, overflow<=1, contents unchanged.
//  Push when full with pop same cycle: both happen, count stays FIFO_DEPTH.
//  Push and pop when empty: push only (no bypass), count becomes 1.
//  out_ready while empty: ignored, no pointer movement.
//  clear_ovf and new drop same cycle: overflow stays 1 (set wins).
//  Reset mid-operation discards in-flight pipeline and FIFO contents; an
//   acc_valid while reset is high is ignored.
// TESTING
//  T1 acc_a=1000, acc_b=-1000, shift=4, ready=1 -> 3 cycles later
//     out_data=16'hC23F (B=-62, A=63), out_valid one cycle.
//  T2 acc_a=24/acc_b=-24, shift=4 -> A=2, B=-1 (out_data=16'hFF02);
//     shift=0, acc_a=5, acc_b=-5 -> 16'hFB05.
//  T3 saturation: acc_a=1048575, acc_b=-2097152, shift=0 -> 16'h807F;
//     shift=31 clamped to 21: acc_a=-2097152 -> A=-1.
//  T4 out_ready=0, 5 consecutive acc_valid with acc_a=1..5, shift=0 ->
//     fifo_count=4, overflow=1, then ready=1 drains A=1,2,3,4 in order.
//  T5 FIFO full, out_ready=1 same cycle as a push -> count stays 4, no
//     overflow, pushed entry appears after the three older ones.
//  T6 reset asserted with 3 entries queued and 2 in pipeline -> out_valid,
//     fifo_count, overflow 0 immediately; nothing emerges after release.

Source files
------------

// File: rtl/pe_requant_drain.sv
// Requantizes the dual-lane PE accumulators to int8 pairs and queues them for a valid/ready consumer.
// Latency 3 cycles from acc_valid to out_valid. One result can be accepted every cycle.
// There is no input backpressure: a result that arrives while the FIFO is full with no pop is dropped and flagged in overflow.
module pe_requant_drain #(
    parameter int ACC_WIDTH   = 22,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           acc_valid,
    input  logic [ACC_WIDTH-1:0]           acc_a,
    input  logic [ACC_WIDTH-1:0]           acc_b,
    input  logic [SHIFT_WIDTH-1:0]         shift,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*OUT_WIDTH-1:0]         out_data,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow,
    input  logic                           clear_ovf
);

    localparam int EXT_W = ACC_WIDTH + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    // Shifting by the full accumulator width or more adds nothing, so clamp to the top bit.
    localparam logic [SHIFT_WIDTH-1:0]  SH_MAX  = SHIFT_WIDTH'(ACC_WIDTH - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    // One extra bit of headroom keeps the rounding add from wrapping.
    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    function automatic logic signed [EXT_W-1:0] requant(
        input logic [ACC_WIDTH-1:0]   acc,
        input logic [SHIFT_WIDTH-1:0] s
    );
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] rnd;
        ext = $signed({acc[ACC_WIDTH-1], acc});
        rnd = '0;
        if (s != '0)
            rnd = $signed(EXT_W'(1) << (s - SHIFT_WIDTH'(1)));
        return (ext + rnd) >>> s;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [EXT_W-1:0] r);
        logic [OUT_WIDTH-1:0] res;
        if (r > SAT_MAX)
            res = SAT_MAX[OUT_WIDTH-1:0];
        else if (r < SAT_MIN)
            res = SAT_MIN[OUT_WIDTH-1:0];
        else
            res = r[OUT_WIDTH-1:0];
        return res;
    endfunction

    logic                    s1_vld;
    logic [ACC_WIDTH-1:0]    s1_a;
    logic [ACC_WIDTH-1:0]    s1_b;
    logic [SHIFT_WIDTH-1:0]  s1_sh;
    logic                    s2_vld;
    logic signed [EXT_W-1:0] s2_ra;
    logic signed [EXT_W-1:0] s2_rb;
    logic [2*OUT_WIDTH-1:0]  push_dat;

    // Stage 1: capture the accumulator pair and the clamped shift amount.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_sh  <= '0;
        end else begin
            s1_vld <= acc_valid;
            if (acc_valid) begin
                s1_a  <= acc_a;
                s1_b  <= acc_b;
                s1_sh <= (shift > SH_MAX) ? SH_MAX : shift;
            end
        end
    end

    // Stage 2: apply the rounding right shift to each lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vld <= 1'b0;
            s2_ra  <= '0;
            s2_rb  <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_ra <= requant(s1_a, s1_sh);
                s2_rb <= requant(s1_b, s1_sh);
            end
        end
    end

    // Stage 3 saturates combinationally and writes straight into the FIFO.
    assign push_dat = {saturate(s2_rb), saturate(s2_ra)};

    logic [2*OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   full;
    logic                   pop;
    logic                   wr_en;
    logic                   drop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is not dropped then.
    // There is no bypass path: a push into an empty FIFO only becomes visible on the next cycle.
    assign full       = (count == CW'(FIFO_DEPTH));
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign wr_en      = s2_vld && (!full || pop);
    assign drop       = s2_vld && full && !pop;
    assign fifo_count = count;
    assign out_data   = out_valid ? mem[rd_ptr] : '0;

    // Storage array: written at the tail, never reset (gated by count on the read side).
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= push_dat;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clear_ovf)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_pe_requant_drain.sv
// Directed bench for pe_requant_drain: rounding, saturation, shift clamp, FIFO full/overflow, async reset.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are hand-computed constants.
module tb_pe_requant_drain;

    logic        clk;
    logic        reset;
    logic        acc_valid;
    logic [21:0] acc_a;
    logic [21:0] acc_b;
    logic [4:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        clear_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    pe_requant_drain #(
        .ACC_WIDTH   (22),
        .OUT_WIDTH   (8),
        .SHIFT_WIDTH (5),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .acc_valid  (acc_valid),
        .acc_a      (acc_a),
        .acc_b      (acc_b),
        .shift      (shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one acc_valid pulse starting at the current falling edge; returns one cycle later.
    task automatic send(input int a, input int b, input int s);
        acc_valid = 1'b1;
        acc_a     = 22'(a);
        acc_b     = 22'(b);
        shift     = 5'(s);
        tick();
        acc_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        acc_valid = 1'b0;
        acc_a     = '0;
        acc_b     = '0;
        shift     = '0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        tick();

        // T1: rounding shift, latency and single-cycle visibility with ready high
        out_ready = 1'b1;
        send(1000, -1000, 4);
        tick();
        check("t1_not_early", 32'(out_valid), 32'd0);
        tick();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h0000C23F);
        check("t1_count", 32'(fifo_count), 32'd1);
        tick();
        check("t1_popped", 32'(out_valid), 32'd0);

        // T2: round half toward +inf, and shift=0 pass-through
        send(24, -24, 4);
        tick();
        tick();
        check("t2_round", 32'(out_data), 32'h0000FF02);
        send(5, -5, 0);
        tick();
        tick();
        check("t2_noshift", 32'(out_data), 32'h0000FB05);

        // T3: saturation on both rails, then shift=31 clamped to 21
        send(1048575, -2097152, 0);
        tick();
        tick();
        check("t3_sat", 32'(out_data), 32'h0000807F);
        send(-2097152, 2097151, 31);
        tick();
        tick();
        check("t3_clamp", 32'(out_data), 32'h000001FF);
        tick();
        check("t3_empty", 32'(out_valid), 32'd0);

        // T4: five results with the consumer stalled; the fifth is dropped
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            acc_valid = 1'b1;
            acc_a     = 22'(i);
            acc_b     = '0;
            shift     = '0;
            tick();
        end
        acc_valid = 1'b0;
        repeat (4) tick();
        check("t4_count", 32'(fifo_count), 32'd4);
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_head", 32'(out_data), 32'h00000001);
        tick();
        check("t4_head_stable", 32'(out_data), 32'h00000001);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t4_drain%0d", i), 32'(out_data), 32'(i));
            tick();
        end
        check("t4_drained", 32'(fifo_count), 32'd0);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        tick();
        check("t4_ready_empty", 32'(fifo_count), 32'd0);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("t4_ovf_clear", 32'(overflow), 32'd0);

        // T5: push into a full FIFO in the same cycle as a pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc_valid = 1'b1;
            acc_a     = 22'(16 + i);
            acc_b     = '0;
            shift     = '0;
            tick();
        end
        acc_valid = 1'b0;
        repeat (4) tick();
        check("t5_full", 32'(fifo_count), 32'd4);
        send(20, 0, 0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_count", 32'(fifo_count), 32'd4);
        check("t5_no_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_order%0d", i), 32'(out_data), 32'(17 + i));
            tick();
        end
        check("t5_drained", 32'(out_valid), 32'd0);

        // T6: async reset with three entries queued and two in the pipeline
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            acc_valid = 1'b1;
            acc_a     = 22'(33 + i);
            acc_b     = '0;
            shift     = '0;
            tick();
        end
        acc_valid = 1'b0;
        check("t6_queued", 32'(fifo_count), 32'd3);
        reset     = 1'b1;
        acc_valid = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_ovf", 32'(overflow), 32'd0);
        tick();
        acc_valid = 1'b0;
        reset     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6_quiet%0d", i), 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
